// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR pseudo-random generator with seed load, wrap detection and period measurement.
// Optional all-zero lock-up guard enabled by defining LFSR_ZERO_GUARD_EN.
module lfsr_prng #(
  parameter int                 WIDTH        = 4,
  parameter logic [WIDTH-1:0]   TAPS         = 4'b1100,
  parameter logic [WIDTH-1:0]   DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             q,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup
);

  logic [WIDTH-1:0] ref_seed;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] state_nxt;
  logic             fb;

  assign fb        = ^(state & TAPS);
  assign state_nxt = {state[WIDTH-2:0], fb};
  assign q         = state[WIDTH-1];

`ifdef LFSR_ZERO_GUARD_EN
  logic lockup_r;
  assign lockup = lockup_r;

  // NOTE: all state registers use non-blocking assignments so every update
  // in this block sees the pre-edge values of state, cnt and ref_seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DEFAULT_SEED;
      ref_seed <= DEFAULT_SEED;
      cnt      <= '0;
      period   <= '0;
      wrap     <= 1'b0;
      lockup_r <= 1'b0;
    end else if (load) begin
      // A zero seed would freeze the register, so substitute the default.
      if (seed == '0) begin
        state    <= DEFAULT_SEED;
        ref_seed <= DEFAULT_SEED;
        lockup_r <= 1'b1;
      end else begin
        state    <= seed;
        ref_seed <= seed;
      end
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      if (state_nxt == '0) begin
        state    <= DEFAULT_SEED;
        lockup_r <= 1'b1;
        wrap     <= 1'b0;
        cnt      <= '0;
      end else if (state_nxt == ref_seed) begin
        state  <= state_nxt;
        wrap   <= 1'b1;
        period <= cnt + WIDTH'(1);
        cnt    <= '0;
      end else begin
        state <= state_nxt;
        wrap  <= 1'b0;
        cnt   <= cnt + WIDTH'(1);
      end
    end else begin
      wrap <= 1'b0;
    end
  end
`else
  assign lockup = 1'b0;

  // NOTE: all state registers use non-blocking assignments so every update
  // in this block sees the pre-edge values of state, cnt and ref_seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DEFAULT_SEED;
      ref_seed <= DEFAULT_SEED;
      cnt      <= '0;
      period   <= '0;
      wrap     <= 1'b0;
    end else if (load) begin
      state    <= seed;
      ref_seed <= seed;
      cnt      <= '0;
      wrap     <= 1'b0;
    end else if (en) begin
      state <= state_nxt;
      // A zero seed gives state_nxt == ref_seed every step: period 1.
      if (state_nxt == ref_seed) begin
        wrap   <= 1'b1;
        period <= cnt + WIDTH'(1);
        cnt    <= '0;
      end else begin
        wrap <= 1'b0;
        cnt  <= cnt + WIDTH'(1);
      end
    end else begin
      wrap <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: scoreboard of a 4-bit reference model plus
// fixed sequence checks, and an 8-bit instance checking the maximal period.
module tb_lfsr_prng;

  typedef struct {
    logic [3:0] state;
    logic       q;
    logic       wrap;
    logic [3:0] period;
    logic       lockup;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] seed = '0;
  logic [3:0] state;
  logic       q;
  logic       wrap;
  logic [3:0] period;
  logic       lockup;

  logic       en8 = 1'b0;
  logic [7:0] state8;
  logic       q8;
  logic       wrap8;
  logic [7:0] period8;
  logic       lockup8;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];

  // reference model state
  logic [3:0] m_state, m_ref, m_cnt, m_period;
  logic       m_wrap, m_lock;

  always #5 clk = ~clk;

  lfsr_prng dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed),
    .state(state), .q(q), .wrap(wrap), .period(period), .lockup(lockup)
  );

  lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .DEFAULT_SEED(8'h01)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .load(1'b0), .seed(8'h00),
    .state(state8), .q(q8), .wrap(wrap8), .period(period8), .lockup(lockup8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 4'b0001; m_ref = 4'b0001; m_cnt = '0; m_period = '0;
    m_wrap = 1'b0; m_lock = 1'b0;
  endtask

  // Model x^4+x^3+1 written directly on bit positions.
  task automatic m_update(input logic l, input logic e, input logic [3:0] s);
    logic [3:0] nxt;
    if (l) begin
`ifdef LFSR_ZERO_GUARD_EN
      if (s == 4'd0) begin
        m_state = 4'b0001; m_ref = 4'b0001; m_lock = 1'b1;
      end else begin
        m_state = s; m_ref = s;
      end
`else
      m_state = s; m_ref = s;
`endif
      m_cnt = '0; m_wrap = 1'b0;
    end else if (e) begin
      nxt = {m_state[2], m_state[1], m_state[0], m_state[3] ^ m_state[2]};
      m_state = nxt;
      if (nxt == m_ref) begin
        m_wrap = 1'b1; m_period = m_cnt + 4'd1; m_cnt = '0;
      end else begin
        m_wrap = 1'b0; m_cnt = m_cnt + 4'd1;
      end
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic cycle(input logic l, input logic e, input logic [3:0] s);
    exp_t x;
    load = l; en = e; seed = s;
    m_update(l, e, s);
    x.state = m_state; x.q = m_state[3]; x.wrap = m_wrap;
    x.period = m_period; x.lockup = m_lock;
    exp_q.push_back(x);
    @(posedge clk); #1;
    x = exp_q.pop_front();
    check("state", 32'(state), 32'(x.state));
    check("q", 32'(q), 32'(x.q));
    check("wrap", 32'(wrap), 32'(x.wrap));
    check("period", 32'(period), 32'(x.period));
    check("lockup", 32'(lockup), 32'(x.lockup));
    load = 1'b0; en = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [5];
    int steps;
    seq[0] = 4'b0110; seq[1] = 4'b1101; seq[2] = 4'b1010; seq[3] = 4'b0101; seq[4] = 4'b1011;
    m_reset();

    // Reset defaults with clock running
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'h1);
    check("rst_q", 32'(q), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_period", 32'(period), 32'h0);
    check("rst_lockup", 32'(lockup), 32'h0);
    rst_n = 1'b1;

    // Load 0011 then the first five steps
    cycle(1'b1, 1'b0, 4'b0011);
    check("load_0011", 32'(state), 32'h3);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 4'b0000);
      check($sformatf("seq%0d", i), 32'(state), 32'(seq[i]));
      check($sformatf("seq_q%0d", i), 32'(q), 32'(seq[i][3]));
    end

    // Complete the cycle: wrap on the 15th step
    for (int i = 5; i < 15; i++) cycle(1'b0, 1'b1, 4'b0000);
    check("wrap15", 32'(wrap), 32'h1);
    check("wrap15_state", 32'(state), 32'h3);
    check("period15", 32'(period), 32'd15);
    cycle(1'b0, 1'b1, 4'b0000);
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // Second wrap 15 steps after the first, with a 3-cycle pause inside
    steps = 1;
    for (int i = 0; i < 6; i++) begin cycle(1'b0, 1'b1, 4'b0000); steps++; end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'b0000);
    check("pause_hold", 32'(state), 32'(m_state));
    for (int i = 0; i < 40 && !wrap; i++) begin cycle(1'b0, 1'b1, 4'b0000); steps++; end
    check("second_wrap_steps", 32'(steps), 32'd15);
    check("second_wrap_period", 32'(period), 32'd15);

    // Load and en together: load wins
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b1, 1'b1, 4'b1001);
    check("load_pri", 32'(state), 32'h9);
    cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0000);

    // Asynchronous reset mid-run, away from a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'h1);
    check("async_period", 32'(period), 32'h0);
    check("async_wrap", 32'(wrap), 32'h0);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    // cnt restarted: wrap back to 0001 after exactly 15 steps
    steps = 0;
    for (int i = 0; i < 40 && !wrap; i++) begin cycle(1'b0, 1'b1, 4'b0000); steps++; end
    check("post_rst_steps", 32'(steps), 32'd15);

    // 8-bit maximal sequence
    steps = 0;
    en8 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      steps++;
      if (wrap8) break;
    end
    en8 = 1'b0;
    check("w8_steps", 32'(steps), 32'd255);
    check("w8_period", 32'(period8), 32'd255);
    check("w8_state", 32'(state8), 32'h01);

    // Zero seed
    cycle(1'b1, 1'b0, 4'b0000);
`ifdef LFSR_ZERO_GUARD_EN
    check("zero_guard_state", 32'(state), 32'h1);
    check("zero_guard_lockup", 32'(lockup), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'b0000);
    check("lockup_sticky", 32'(lockup), 32'h1);
`else
    check("zero_state", 32'(state), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 4'b0000);
      check("zero_wrap", 32'(wrap), 32'h1);
      check("zero_period", 32'(period), 32'h1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
